// File: rtl/onehot_mux_8_pkg.sv
// Shared definitions for the one-hot way multiplexer: default sizes and the
// select-vector classifier used to raise the select-error flag.
package onehot_mux_8_pkg;

  localparam int DEFAULT_NUMBER_WAYS      = 8;
  localparam int DEFAULT_ELEMENT_BITS     = 4;
  localparam int MAX_WAYS                 = 64;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_e;

  // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  function automatic sel_class_e onehot_check(input logic [MAX_WAYS-1:0] sel);
    sel_class_e cls;
    if (sel == '0) begin
      cls = SEL_NONE;
    end else if ((sel & (sel - 1'b1)) == '0) begin
      cls = SEL_ONE;
    end else begin
      cls = SEL_MULTI;
    end
    return cls;
  endfunction

endpackage

// File: rtl/onehot_mux_8_if.sv
// Bus bundle for the one-hot multiplexer: packed ways and select in,
// combinational and registered selection plus select-error flag out.
interface onehot_mux_8_if #(
  parameter int NUMBER_WAYS                 = 8,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 4
);

  logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] way_packed_in;
  logic [NUMBER_WAYS-1:0]                             sel_in;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             way_packed_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             way_packed_out_q;
  logic                                               sel_error_out;

  modport master (
    output way_packed_in,
    output sel_in,
    input  way_packed_out,
    input  way_packed_out_q,
    input  sel_error_out
  );

  modport slave (
    input  way_packed_in,
    input  sel_in,
    output way_packed_out,
    output way_packed_out_q,
    output sel_error_out
  );

endinterface

// File: rtl/onehot_mux_8_core.sv
// Purely combinational AND-OR way selector; multi-hot selects OR the chosen
// ways together and an all-zero select yields zero.
module onehot_mux_core #(
  parameter int NUMBER_WAYS                 = 8,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 4
) (
  input  logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] way_packed_in,
  input  logic [NUMBER_WAYS-1:0]                             sel_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             way_packed_out
);

  localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;

  always_comb begin
    way_packed_out = '0;
    for (int unsigned i = 0; i < NUMBER_WAYS; i++) begin
      way_packed_out = way_packed_out | (way_packed_in[i*W +: W] & {W{sel_in[i]}});
    end
  end

endmodule

// File: rtl/onehot_mux_8.sv
// One-hot way multiplexer with a zero-latency selected output, a registered
// copy of it and a registered flag for non-one-hot selects.
module onehot_mux_8
  import onehot_mux_8_pkg::*;
#(
  parameter int NUMBER_WAYS                 = DEFAULT_NUMBER_WAYS,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_BITS
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  onehot_mux_8_if.slave   bus
);

  localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;

  logic [W-1:0]          way_out;
  logic [W-1:0]          way_out_d;
  logic [W-1:0]          way_out_q;
  logic                  sel_error_d;
  logic                  sel_error_q;
  logic [MAX_WAYS-1:0]   sel_ext;
  sel_class_e            sel_class;

  onehot_mux_core #(
    .NUMBER_WAYS                 (NUMBER_WAYS),
    .SINGLE_ELEMENT_SIZE_IN_BITS (SINGLE_ELEMENT_SIZE_IN_BITS)
  ) u_core (
    .way_packed_in  (bus.way_packed_in),
    .sel_in         (bus.sel_in),
    .way_packed_out (way_out)
  );

  // Select is zero-extended into the classifier's fixed-width argument.
  always_comb begin
    sel_ext                    = '0;
    sel_ext[NUMBER_WAYS-1:0]   = bus.sel_in;
    sel_class                  = onehot_check(sel_ext);
    way_out_d                  = way_out;
    sel_error_d                = (sel_class != SEL_ONE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      way_out_q   <= '0;
      sel_error_q <= 1'b0;
    end else begin
      way_out_q   <= way_out_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign bus.way_packed_out   = way_out;
  assign bus.way_packed_out_q = way_out_q;
  assign bus.sel_error_out    = sel_error_q;

endmodule

// File: tb/tb_onehot_mux_8.sv
// Self-checking bench for onehot_mux_8: default 8x4 instance plus a 4x16
// instance, checked against an array-based selection model.
module tb_onehot_mux_8;

  logic clk_in;
  logic reset_n_in;
  int   checks;
  int   failures;

  onehot_mux_8_if bus8 ();
  onehot_mux_8_if #(.NUMBER_WAYS(4), .SINGLE_ELEMENT_SIZE_IN_BITS(16)) bus4 ();

  onehot_mux_8 dut8 (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus8)
  );

  onehot_mux_8 #(.NUMBER_WAYS(4), .SINGLE_ELEMENT_SIZE_IN_BITS(16)) dut4 (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus4)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Unpack ways into an array, then OR every selected element.
  function automatic logic [15:0] ref_mux(input logic [63:0] ways, input logic [7:0] sel,
                                          input int n, input int w);
    logic [15:0] elem [8];
    logic [15:0] r;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    r = '0;
    for (int i = 0; i < n; i++) elem[i] = 16'((ways >> (i * w)) & mask);
    for (int i = 0; i < n; i++) if (sel[i]) r = r | elem[i];
    return r;
  endfunction

  function automatic logic ref_err(input logic [7:0] sel);
    return $countones(sel) != 1;
  endfunction

  task automatic test_reset();
    logic [15:0] e;
    reset_n_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      bus8.way_packed_in = $urandom;
      bus8.sel_in        = 8'($urandom);
      @(posedge clk_in); #1;
      checks += 2;
      if (bus8.way_packed_out_q !== 4'h0) begin
        failures++; $display("FAIL reset_q cycle=%0d got=%h exp=0", c, bus8.way_packed_out_q);
      end
      if (bus8.sel_error_out !== 1'b0) begin
        failures++; $display("FAIL reset_err cycle=%0d got=%b exp=0", c, bus8.sel_error_out);
      end
    end
    @(negedge clk_in);
    reset_n_in         = 1'b1;
    bus8.way_packed_in = 32'h1234_5678;
    bus8.sel_in        = 8'b0000_0110;
    e = ref_mux(64'(bus8.way_packed_in), bus8.sel_in, 8, 4);
    @(posedge clk_in); #1;
    checks += 2;
    if (bus8.way_packed_out_q !== e[3:0]) begin
      failures++; $display("FAIL release_q got=%h exp=%h", bus8.way_packed_out_q, e[3:0]);
    end
    if (bus8.sel_error_out !== 1'b1) begin
      failures++; $display("FAIL release_err got=%b exp=1", bus8.sel_error_out);
    end
  endtask

  task automatic test_walking();
    logic [3:0] e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      bus8.way_packed_in = 32'h1234_5678;
      bus8.sel_in        = 8'(1 << i);
      e = 4'(8 - i);
      #1;
      checks++;
      if (bus8.way_packed_out !== e) begin
        failures++; $display("FAIL walk_comb i=%0d got=%h exp=%h", i, bus8.way_packed_out, e);
      end
      @(posedge clk_in); #1;
      checks += 2;
      if (bus8.way_packed_out_q !== e) begin
        failures++; $display("FAIL walk_q i=%0d got=%h exp=%h", i, bus8.way_packed_out_q, e);
      end
      if (bus8.sel_error_out !== 1'b0) begin
        failures++; $display("FAIL walk_err i=%0d got=%b exp=0", i, bus8.sel_error_out);
      end
    end
  endtask

  task automatic test_select_case(input string name, input logic [31:0] ways,
                                  input logic [7:0] sel, input logic [3:0] exp_out,
                                  input logic exp_err);
    @(negedge clk_in);
    bus8.way_packed_in = ways;
    bus8.sel_in        = sel;
    #1;
    checks++;
    if (bus8.way_packed_out !== exp_out) begin
      failures++; $display("FAIL %s_comb got=%h exp=%h", name, bus8.way_packed_out, exp_out);
    end
    @(posedge clk_in); #1;
    checks += 2;
    if (bus8.way_packed_out_q !== exp_out) begin
      failures++; $display("FAIL %s_q got=%h exp=%h", name, bus8.way_packed_out_q, exp_out);
    end
    if (bus8.sel_error_out !== exp_err) begin
      failures++; $display("FAIL %s_err got=%b exp=%b", name, bus8.sel_error_out, exp_err);
    end
  endtask

  task automatic test_zero_select();
    test_select_case("zero", 32'hFFFF_FFFF, 8'b0000_0000, 4'h0, 1'b1);
  endtask

  task automatic test_multi_hot();
    test_select_case("multi", 32'h0000_0021, 8'b0000_0011, 4'h3, 1'b1);
    test_select_case("multi3", 32'h8421_0000, 8'b1111_0000, 4'hF, 1'b1);
  endtask

  task automatic test_async_reset();
    test_select_case("pre_rst", 32'h1234_5678, 8'b0000_0001, 4'h8, 1'b0);
    @(negedge clk_in); #2;
    reset_n_in = 1'b0;
    #1;
    checks += 3;
    if (bus8.way_packed_out_q !== 4'h0) begin
      failures++; $display("FAIL arst_q got=%h exp=0", bus8.way_packed_out_q);
    end
    if (bus8.sel_error_out !== 1'b0) begin
      failures++; $display("FAIL arst_err got=%b exp=0", bus8.sel_error_out);
    end
    if (bus8.way_packed_out !== 4'h8) begin
      failures++; $display("FAIL arst_comb got=%h exp=8", bus8.way_packed_out);
    end
    #1;
    reset_n_in = 1'b1;
    @(posedge clk_in); #1;
    checks++;
    if (bus8.way_packed_out_q !== 4'h8) begin
      failures++; $display("FAIL arst_recover_q got=%h exp=8", bus8.way_packed_out_q);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic [7:0]  s;
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(2))
        0:       s = 8'(1 << $urandom_range(7));
        1:       s = 8'h00;
        default: s = 8'($urandom);
      endcase
      @(negedge clk_in);
      bus8.way_packed_in = $urandom;
      bus8.sel_in        = s;
      e = ref_mux(64'(bus8.way_packed_in), s, 8, 4);
      #1;
      checks++;
      if (bus8.way_packed_out !== e[3:0]) begin
        failures++; $display("FAIL rand_comb k=%0d sel=%b got=%h exp=%h", k, s, bus8.way_packed_out, e[3:0]);
      end
      @(posedge clk_in); #1;
      checks += 2;
      if (bus8.way_packed_out_q !== e[3:0]) begin
        failures++; $display("FAIL rand_q k=%0d got=%h exp=%h", k, bus8.way_packed_out_q, e[3:0]);
      end
      if (bus8.sel_error_out !== ref_err(s)) begin
        failures++; $display("FAIL rand_err k=%0d sel=%b got=%b exp=%b", k, s, bus8.sel_error_out, ref_err(s));
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] e;
    logic [3:0]  s;
    @(negedge clk_in);
    bus4.way_packed_in = 64'hDDDD_CCCC_BBBB_AAAA;
    bus4.sel_in        = 4'b0100;
    #1;
    checks++;
    if (bus4.way_packed_out !== 16'hCCCC) begin
      failures++; $display("FAIL p4_comb got=%h exp=cccc", bus4.way_packed_out);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      s = 4'($urandom);
      bus4.way_packed_in = {$urandom, $urandom};
      bus4.sel_in        = s;
      e = ref_mux(bus4.way_packed_in, {4'b0, s}, 4, 16);
      #1;
      checks++;
      if (bus4.way_packed_out !== e) begin
        failures++; $display("FAIL p4_rand_comb k=%0d sel=%b got=%h exp=%h", k, s, bus4.way_packed_out, e);
      end
      @(posedge clk_in); #1;
      checks += 2;
      if (bus4.way_packed_out_q !== e) begin
        failures++; $display("FAIL p4_rand_q k=%0d got=%h exp=%h", k, bus4.way_packed_out_q, e);
      end
      if (bus4.sel_error_out !== ref_err({4'b0, s})) begin
        failures++; $display("FAIL p4_rand_err k=%0d sel=%b got=%b", k, s, bus4.sel_error_out);
      end
    end
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    reset_n_in         = 1'b0;
    bus8.way_packed_in = '0;
    bus8.sel_in        = '0;
    bus4.way_packed_in = '0;
    bus4.sel_in        = '0;
    test_reset();
    test_walking();
    test_zero_select();
    test_multi_hot();
    test_async_reset();
    test_random();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
